pipe_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage RISC-V pipeline (F/D/E/M/W pipeline registers).
- Generates E-stage operand forwarding selects, the load-use stall, and branch/jump flushes.
- Generates a whole-pipeline freeze while the data memory is not ready.
- Runs a watchdog FSM that halts the pipeline and raises a sticky error when a data-memory access does not complete.
- Sits beside the pipeline registers and drives their enable and flush inputs.

---
 rtl/pipe_hazard_ctrl_if.sv | 26 ++
 rtl/pipe_hazard_ctrl.sv | 113 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline-side hazard inputs and the
// stall/flush/forward/status outputs returned to the pipeline registers.
interface pipe_hazard_ctrl_if #(parameter int PERF_W = 32);
  logic [4:0]        Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic              RegWriteM, RegWriteW;
  logic [1:0]        ResultSrcE;
  logic              PCSrcE, MemReqM, MemReadyM;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              StallF, StallD, StallE, StallM, StallW;
  logic              FlushD, FlushE, MemErr, Halted;
  logic [PERF_W-1:0] StallCnt, FlushCnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE, PCSrcE, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW,
           FlushD, FlushE, MemErr, Halted, StallCnt, FlushCnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE, PCSrcE, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW,
           FlushD, FlushE, MemErr, Halted, StallCnt, FlushCnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard controller: forwarding, load-use stall, redirect flush,
// memory freeze and data-memory watchdog. HAZ_PERF_CNT_EN builds stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int PERF_W      = 32
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave bus
);
  // MEM_TIMEOUT==0 still needs a 1-bit counter to saturate
  localparam int WCW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] TMO_M1 = WCW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALT} state_t;

  state_t         r_state, w_nxt;
  logic [WCW-1:0] r_wcnt, w_wcnt_nxt;
  logic           r_memerr;
  logic           w_lw, w_freeze, w_hold, w_halt;
  logic [1:0]     w_fwda, w_fwdb;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wm,
                                         input logic [4:0] rdm, input logic ww,
                                         input logic [4:0] rdw);
    if (wm && rdm != 5'd0 && rdm == rs)      return 2'b10;
    else if (ww && rdw != 5'd0 && rdw == rs) return 2'b01;
    else                                     return 2'b00;
  endfunction

  always_comb begin
    w_fwda = fwd_sel(bus.Rs1E, bus.RegWriteM, bus.RdM, bus.RegWriteW, bus.RdW);
    w_fwdb = fwd_sel(bus.Rs2E, bus.RegWriteM, bus.RdM, bus.RegWriteW, bus.RdW);
    w_lw   = (bus.ResultSrcE == 2'b01) && (bus.RdE != 5'd0) &&
             ((bus.Rs1D == bus.RdE) || (bus.Rs2D == bus.RdE));
  end

  assign w_halt   = (r_state == S_HALT);
  assign w_freeze = !w_halt && bus.MemReqM && !bus.MemReadyM;
  assign w_hold   = w_freeze || w_halt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_RUN;
      r_wcnt   <= '0;
      r_memerr <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_wcnt   <= w_wcnt_nxt;
      if (w_nxt == S_HALT) r_memerr <= 1'b1;
    end
  end

  always_comb begin
    w_nxt      = r_state;
    w_wcnt_nxt = r_wcnt;
    case (r_state)
      S_RUN: begin
        if (w_freeze) begin
          if (MEM_TIMEOUT == 1) w_nxt = S_HALT;
          else begin
            w_nxt      = S_WAIT;
            w_wcnt_nxt = WCW'(1);
          end
        end
      end
      S_WAIT: begin
        if (!w_freeze) begin
          w_nxt      = S_RUN;
          w_wcnt_nxt = '0;
        end else if (MEM_TIMEOUT != 0 && r_wcnt == TMO_M1) begin
          w_nxt = S_HALT;
        end else if (r_wcnt != '1) begin
          w_wcnt_nxt = r_wcnt + WCW'(1);
        end
      end
      default: w_nxt = S_HALT;
    endcase
  end

  // Freeze/halt holds every stage and suppresses flushes so a pending redirect survives
  assign bus.ForwardAE = w_fwda;
  assign bus.ForwardBE = w_fwdb;
  assign bus.StallF    = w_hold || w_lw;
  assign bus.StallD    = w_hold || w_lw;
  assign bus.StallE    = w_hold;
  assign bus.StallM    = w_hold;
  assign bus.StallW    = w_hold;
  assign bus.FlushD    = !w_hold && bus.PCSrcE;
  assign bus.FlushE    = !w_hold && (w_lw || bus.PCSrcE);
  assign bus.MemErr    = r_memerr;
  assign bus.Halted    = w_halt;

`ifdef HAZ_PERF_CNT_EN
  logic [PERF_W-1:0] r_scnt, r_fcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scnt <= '0;
      r_fcnt <= '0;
    end else begin
      if (bus.StallF && !w_halt && r_scnt != '1) r_scnt <= r_scnt + PERF_W'(1);
      if (bus.FlushD && r_fcnt != '1)            r_fcnt <= r_fcnt + PERF_W'(1);
    end
  end

  assign bus.StallCnt = r_scnt;
  assign bus.FlushCnt = r_fcnt;
`else
  assign bus.StallCnt = '0;
  assign bus.FlushCnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a rule-level reference model
// (consecutive-frozen-cycle count and halt flag), plus directed hazard scenarios.
module tb_pipe_hazard_ctrl;
  localparam int MT = 4;
  localparam int PW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.PERF_W(PW)) bus();
  pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .PERF_W(PW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;

  int          m_frz;
  bit          m_halt, m_err;
  logic [PW-1:0] m_scnt, m_fcnt;
  logic        e_lw, e_frz, e_hold;
  logic [4:0]  e_stall;
  logic [1:0]  e_flush;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h @%0t", tag, got, exp, $time);
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (bus.RegWriteM && bus.RdM != 0 && bus.RdM == rs) return 2'b10;
    if (bus.RegWriteW && bus.RdW != 0 && bus.RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic m_eval();
    e_lw    = (bus.ResultSrcE == 2'b01) && bus.RdE != 0 &&
              (bus.Rs1D == bus.RdE || bus.Rs2D == bus.RdE);
    e_frz   = !m_halt && bus.MemReqM && !bus.MemReadyM;
    e_hold  = e_frz || m_halt;
    e_stall = {e_hold | e_lw, e_hold | e_lw, e_hold, e_hold, e_hold};
    e_flush = {!e_hold && bus.PCSrcE, !e_hold && (e_lw || bus.PCSrcE)};
  endtask

  task automatic m_reset();
    m_frz = 0; m_halt = 0; m_err = 0; m_scnt = '0; m_fcnt = '0;
  endtask

  task automatic check_all();
    m_eval();
    chk("fwdA",   bus.ForwardAE, m_fwd(bus.Rs1E));
    chk("fwdB",   bus.ForwardBE, m_fwd(bus.Rs2E));
    chk("stall",  {bus.StallF, bus.StallD, bus.StallE, bus.StallM, bus.StallW}, e_stall);
    chk("flush",  {bus.FlushD, bus.FlushE}, e_flush);
    chk("memerr", bus.MemErr, m_err);
    chk("halted", bus.Halted, m_halt);
    chk("scnt",   bus.StallCnt, m_scnt);
    chk("fcnt",   bus.FlushCnt, m_fcnt);
  endtask

  // Called at a negedge with inputs set; returns at the following negedge
  task automatic step();
    #1 check_all();
    @(posedge clk);
    m_eval();
`ifdef HAZ_PERF_CNT_EN
    if (e_stall[4] && !m_halt && m_scnt != '1) m_scnt++;
    if (e_flush[1] && m_fcnt != '1)            m_fcnt++;
`endif
    if (!m_halt) begin
      if (e_frz) begin
        m_frz++;
        if (MT != 0 && m_frz >= MT) begin m_halt = 1; m_err = 1; end
      end else m_frz = 0;
    end
    @(negedge clk);
  endtask

  task automatic pulse_rst();
    #2 rst = 1'b1;
    #1 m_reset();
    check_all();
    chk("rst_halted", bus.Halted, 1'b0);
    chk("rst_memerr", bus.MemErr, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle();
    bus.Rs1D = 0; bus.Rs2D = 0; bus.Rs1E = 0; bus.Rs2E = 0;
    bus.RdE = 0; bus.RdM = 0; bus.RdW = 0;
    bus.RegWriteM = 0; bus.RegWriteW = 0; bus.ResultSrcE = 0;
    bus.PCSrcE = 0; bus.MemReqM = 0; bus.MemReadyM = 1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    m_reset();
    #1 check_all();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // forwarding priority
    bus.RegWriteM = 1; bus.RdM = 5; bus.RegWriteW = 1; bus.RdW = 5; bus.Rs1E = 5;
    #1 chk("fwdA_M", bus.ForwardAE, 2'b10);
    chk("fwdB_x0", bus.ForwardBE, 2'b00);
    step();
    bus.RdM = 0;
    #1 chk("fwdA_W", bus.ForwardAE, 2'b01);
    step();

    // load-use
    idle(); bus.ResultSrcE = 2'b01; bus.RdE = 7; bus.Rs2D = 7;
    #1 chk("lu_stall", {bus.StallF, bus.StallD, bus.StallE}, 3'b110);
    chk("lu_flush", {bus.FlushD, bus.FlushE}, 2'b01);
    step();
    bus.RdE = 0;
    #1 chk("lu_x0", {bus.StallF, bus.FlushE}, 2'b00);
    step();

    // branch, then branch coinciding with load-use
    idle(); bus.PCSrcE = 1;
    #1 chk("br_flush", {bus.FlushD, bus.FlushE, bus.StallF}, 3'b110);
    step();
    bus.ResultSrcE = 2'b01; bus.RdE = 3; bus.Rs1D = 3;
    #1 chk("br_lu", {bus.FlushD, bus.FlushE, bus.StallF, bus.StallD}, 4'b1111);
    step();

    // short memory wait with a redirect held across the freeze
    idle(); bus.MemReqM = 1; bus.MemReadyM = 0; bus.PCSrcE = 1;
    repeat (3) begin
      #1 chk("frz_stall", {bus.StallF, bus.StallD, bus.StallE, bus.StallM, bus.StallW}, 5'h1f);
      chk("frz_noflush", bus.FlushD, 1'b0);
      step();
    end
    bus.MemReadyM = 1;
    #1 chk("rdy_flushD", bus.FlushD, 1'b1);
    step();
    chk("rdy_noerr", bus.MemErr, 1'b0);

    // watchdog: MT frozen cycles then halt, sticky until reset
    idle(); bus.MemReqM = 1; bus.MemReadyM = 0;
    repeat (MT) step();
    #1 chk("wd_halt", {bus.Halted, bus.MemErr}, 2'b11);
    step();
    bus.MemReadyM = 1;
    step(); step();
    chk("wd_stuck", {bus.Halted, bus.StallW, bus.FlushD}, 3'b110);
    pulse_rst();

    // async reset mid-WAIT
    idle(); bus.MemReqM = 1; bus.MemReadyM = 0;
    step(); step();
    pulse_rst();

    // randomized traffic with periodic resets
    for (int i = 0; i < 1500; i++) begin
      if (i % 70 == 69) begin
        pulse_rst();
      end else begin
        bus.Rs1D = 5'($urandom_range(0, 3)); bus.Rs2D = 5'($urandom_range(0, 3));
        bus.Rs1E = 5'($urandom_range(0, 3)); bus.Rs2E = 5'($urandom_range(0, 3));
        bus.RdE  = 5'($urandom_range(0, 3)); bus.RdM  = 5'($urandom_range(0, 3));
        bus.RdW  = 5'($urandom_range(0, 3));
        bus.RegWriteM  = 1'($urandom_range(0, 1));
        bus.RegWriteW  = 1'($urandom_range(0, 1));
        bus.ResultSrcE = 2'($urandom_range(0, 3));
        bus.PCSrcE     = ($urandom_range(0, 3) == 0);
        bus.MemReqM    = 1'($urandom_range(0, 1));
        bus.MemReadyM  = ($urandom_range(0, 3) != 0);
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
